// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared widths and the per-stage tag record for the RV32 core.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic                 is_load;
        logic                 is_store;
        logic                 is_branch;
    } stage_tag_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_max = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_count <= '0;
        end else if (inc && (r_count != c_max)) begin
            r_count <= r_count + c_one;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_stage_regs.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stage_regs
// Description : IF/ID/EX/MEM/WB valid, PC and tag registers with hazard-unit
//               hold/kill controls and saturating performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stage_regs
    import cpu_pkg::stage_tag_t, cpu_pkg::REG_IDX_W;
#(
    parameter int XLEN  = cpu_pkg::XLEN,
    parameter int CNT_W = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_valid,
    input  logic [XLEN-1:0]      IF_PC,
    input  logic [REG_IDX_W-1:0] dec_rd,
    input  logic                 dec_is_load,
    input  logic                 dec_is_store,
    input  logic                 dec_is_branch,
    input  logic                 stop_IF,
    input  logic                 stop_ID,
    input  logic                 set_invalid_IF,
    input  logic                 set_invalid_ID,
    input  logic                 set_invalid_EX,
    input  logic                 set_invalid_MEM,
    input  logic                 set_invalid_WB,
    output logic [XLEN-1:0]      ID_PC,
    output logic [XLEN-1:0]      EX_PC,
    output logic [XLEN-1:0]      MEM_PC,
    output logic [XLEN-1:0]      WB_PC,
    output logic                 ID_invalid,
    output logic                 EX_invalid,
    output logic                 MEM_invalid,
    output logic                 WB_invalid,
    output logic [REG_IDX_W-1:0] rd,
    output logic                 is_load_EX,
    output logic                 is_store_EX,
    output logic                 is_branch_EX,
    output logic                 is_load_MEM,
    output logic                 retire,
    output logic [CNT_W-1:0]     instret,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_cycles
);

    logic            r_v_if, r_v_id, r_v_ex, r_v_mem, r_v_wb;
    logic [XLEN-1:0] r_id_pc, r_ex_pc, r_mem_pc, r_wb_pc;
    stage_tag_t      r_ex_tag;
    logic            r_mem_is_load;

    logic            w_v_if_nxt, w_v_id_nxt, w_v_ex_nxt, w_v_mem_nxt, w_v_wb_nxt;
    logic [XLEN-1:0] w_id_pc_nxt, w_ex_pc_nxt;
    stage_tag_t      w_ex_tag_nxt;

    // Kills only clear valid bits; PC/tag registers keep following the
    // hold/advance rules so EX_PC stays meaningful for the hazard compare.
    always_comb begin
        w_v_if_nxt   = stop_IF ? r_v_if : fetch_valid;
        w_id_pc_nxt  = stop_ID ? r_id_pc : IF_PC;
        w_v_id_nxt   = stop_ID ? r_v_id : (r_v_if & ~stop_IF);
        w_ex_pc_nxt  = stop_ID ? r_ex_pc : r_id_pc;
        w_ex_tag_nxt = stop_ID ? r_ex_tag
                               : stage_tag_t'{rd: dec_rd, is_load: dec_is_load,
                                              is_store: dec_is_store, is_branch: dec_is_branch};
        w_v_ex_nxt   = r_v_id & ~stop_ID;
        w_v_mem_nxt  = r_v_ex;
        w_v_wb_nxt   = r_v_mem;

        if (set_invalid_IF)  w_v_if_nxt  = 1'b0;
        if (set_invalid_ID)  w_v_id_nxt  = 1'b0;
        if (set_invalid_EX)  w_v_ex_nxt  = 1'b0;
        if (set_invalid_MEM) w_v_mem_nxt = 1'b0;
        if (set_invalid_WB)  w_v_wb_nxt  = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v_if        <= 1'b0;
            r_v_id        <= 1'b0;
            r_v_ex        <= 1'b0;
            r_v_mem       <= 1'b0;
            r_v_wb        <= 1'b0;
            r_id_pc       <= '0;
            r_ex_pc       <= '0;
            r_mem_pc      <= '0;
            r_wb_pc       <= '0;
            r_ex_tag      <= '0;
            r_mem_is_load <= 1'b0;
        end else begin
            r_v_if        <= w_v_if_nxt;
            r_v_id        <= w_v_id_nxt;
            r_v_ex        <= w_v_ex_nxt;
            r_v_mem       <= w_v_mem_nxt;
            r_v_wb        <= w_v_wb_nxt;
            r_id_pc       <= w_id_pc_nxt;
            r_ex_pc       <= w_ex_pc_nxt;
            r_mem_pc      <= r_ex_pc;
            r_wb_pc       <= r_mem_pc;
            r_ex_tag      <= w_ex_tag_nxt;
            r_mem_is_load <= r_ex_tag.is_load;
        end
    end

    assign ID_PC        = r_id_pc;
    assign EX_PC        = r_ex_pc;
    assign MEM_PC       = r_mem_pc;
    assign WB_PC        = r_wb_pc;
    assign ID_invalid   = ~r_v_id;
    assign EX_invalid   = ~r_v_ex;
    assign MEM_invalid  = ~r_v_mem;
    assign WB_invalid   = ~r_v_wb;
    assign rd           = r_v_id ? dec_rd : '0;
    assign is_load_EX   = r_ex_tag.is_load   & r_v_ex;
    assign is_store_EX  = r_ex_tag.is_store  & r_v_ex;
    assign is_branch_EX = r_ex_tag.is_branch & r_v_ex;
    assign is_load_MEM  = r_mem_is_load      & r_v_mem;
    assign retire       = r_v_wb;

    sat_counter #(.CNT_W(CNT_W)) u_instret (
        .clk   (clk),
        .clear (reset),
        .inc   (r_v_wb),
        .count (instret)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall (
        .clk   (clk),
        .clear (reset),
        .inc   (stop_ID),
        .count (stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush (
        .clk   (clk),
        .clear (reset),
        .inc   (set_invalid_ID),
        .count (flush_cycles)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stage_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_stage_regs
// Description : Self-checking bench: directed vector table, hand sequences and
//               random traffic against a slot-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stage_regs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, fetch_valid, dec_is_load, dec_is_store, dec_is_branch;
    logic        stop_IF, stop_ID;
    logic [4:0]  si;
    logic [31:0] IF_PC;
    logic [4:0]  dec_rd;

    logic [31:0] ID_PC, EX_PC, MEM_PC, WB_PC;
    logic        ID_invalid, EX_invalid, MEM_invalid, WB_invalid;
    logic [4:0]  rd;
    logic        is_load_EX, is_store_EX, is_branch_EX, is_load_MEM, retire;
    logic [63:0] instret, stall_cycles, flush_cycles;

    logic [31:0] s_ID_PC, s_EX_PC, s_MEM_PC, s_WB_PC;
    logic        s_ID_invalid, s_EX_invalid, s_MEM_invalid, s_WB_invalid;
    logic [4:0]  s_rd;
    logic        s_is_load_EX, s_is_store_EX, s_is_branch_EX, s_is_load_MEM, s_retire;
    logic [3:0]  s_instret, s_stall_cycles, s_flush_cycles;

    pipeline_stage_regs #(.XLEN(32), .CNT_W(64)) dut (
        .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .IF_PC(IF_PC),
        .dec_rd(dec_rd), .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
        .dec_is_branch(dec_is_branch), .stop_IF(stop_IF), .stop_ID(stop_ID),
        .set_invalid_IF(si[0]), .set_invalid_ID(si[1]), .set_invalid_EX(si[2]),
        .set_invalid_MEM(si[3]), .set_invalid_WB(si[4]),
        .ID_PC(ID_PC), .EX_PC(EX_PC), .MEM_PC(MEM_PC), .WB_PC(WB_PC),
        .ID_invalid(ID_invalid), .EX_invalid(EX_invalid), .MEM_invalid(MEM_invalid),
        .WB_invalid(WB_invalid), .rd(rd), .is_load_EX(is_load_EX),
        .is_store_EX(is_store_EX), .is_branch_EX(is_branch_EX), .is_load_MEM(is_load_MEM),
        .retire(retire), .instret(instret), .stall_cycles(stall_cycles),
        .flush_cycles(flush_cycles)
    );

    pipeline_stage_regs #(.XLEN(32), .CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .IF_PC(IF_PC),
        .dec_rd(dec_rd), .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
        .dec_is_branch(dec_is_branch), .stop_IF(stop_IF), .stop_ID(stop_ID),
        .set_invalid_IF(si[0]), .set_invalid_ID(si[1]), .set_invalid_EX(si[2]),
        .set_invalid_MEM(si[3]), .set_invalid_WB(si[4]),
        .ID_PC(s_ID_PC), .EX_PC(s_EX_PC), .MEM_PC(s_MEM_PC), .WB_PC(s_WB_PC),
        .ID_invalid(s_ID_invalid), .EX_invalid(s_EX_invalid), .MEM_invalid(s_MEM_invalid),
        .WB_invalid(s_WB_invalid), .rd(s_rd), .is_load_EX(s_is_load_EX),
        .is_store_EX(s_is_store_EX), .is_branch_EX(s_is_branch_EX),
        .is_load_MEM(s_is_load_MEM), .retire(s_retire), .instret(s_instret),
        .stall_cycles(s_stall_cycles), .flush_cycles(s_flush_cycles)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each stage is a slot holding one instruction (or a bubble).
    typedef struct {
        bit          v;
        logic [31:0] pc;
        bit          ld, st, br;
    } slot_t;

    slot_t   m_id, m_ex, m_mem, m_wb;
    bit      m_vif;
    longint  m_instret, m_stall, m_flush;

    function automatic longint sat4(input longint x);
        return (x > 15) ? 15 : x;
    endfunction

    task automatic model_step();
        slot_t n_id, n_ex, n_mem, n_wb;
        bit    n_vif;
        if (reset) begin
            m_id = '{0, 0, 0, 0, 0}; m_ex = m_id; m_mem = m_id; m_wb = m_id;
            m_vif = 0; m_instret = 0; m_stall = 0; m_flush = 0;
            return;
        end
        if (m_wb.v)  m_instret++;
        if (stop_ID) m_stall++;
        if (si[1])   m_flush++;
        n_vif = stop_IF ? m_vif : fetch_valid;
        n_mem = m_ex;
        n_wb  = m_mem;
        if (stop_ID) begin
            n_id   = m_id;
            n_ex   = m_ex;
            n_ex.v = 0;
        end else begin
            n_id = '{m_vif && !stop_IF, IF_PC, 0, 0, 0};
            n_ex = '{m_id.v, m_id.pc, dec_is_load, dec_is_store, dec_is_branch};
        end
        if (si[0]) n_vif   = 0;
        if (si[1]) n_id.v  = 0;
        if (si[2]) n_ex.v  = 0;
        if (si[3]) n_mem.v = 0;
        if (si[4]) n_wb.v  = 0;
        m_vif = n_vif; m_id = n_id; m_ex = n_ex; m_mem = n_mem; m_wb = n_wb;
    endtask

    task automatic check_model();
        chk("ID_PC", ID_PC, m_id.pc);
        chk("EX_PC", EX_PC, m_ex.pc);
        chk("MEM_PC", MEM_PC, m_mem.pc);
        chk("WB_PC", WB_PC, m_wb.pc);
        chk("ID_invalid", ID_invalid, !m_id.v);
        chk("EX_invalid", EX_invalid, !m_ex.v);
        chk("MEM_invalid", MEM_invalid, !m_mem.v);
        chk("WB_invalid", WB_invalid, !m_wb.v);
        chk("rd", rd, m_id.v ? dec_rd : 5'd0);
        chk("is_load_EX", is_load_EX, m_ex.v && m_ex.ld);
        chk("is_store_EX", is_store_EX, m_ex.v && m_ex.st);
        chk("is_branch_EX", is_branch_EX, m_ex.v && m_ex.br);
        chk("is_load_MEM", is_load_MEM, m_mem.v && m_mem.ld);
        chk("retire", retire, m_wb.v);
        chk("instret", instret, m_instret);
        chk("stall_cycles", stall_cycles, m_stall);
        chk("flush_cycles", flush_cycles, m_flush);
        chk("instret_w4", s_instret, sat4(m_instret));
        chk("stall_w4", s_stall_cycles, sat4(m_stall));
        chk("flush_w4", s_flush_cycles, sat4(m_flush));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic drive(input bit fv, input logic [31:0] pc, input bit sif, input bit sid,
                         input logic [4:0] inv, input logic [4:0] drd, input bit dld);
        reset = 0; fetch_valid = fv; IF_PC = pc; stop_IF = sif; stop_ID = sid; si = inv;
        dec_rd = drd; dec_is_load = dld; dec_is_store = 0; dec_is_branch = 0;
    endtask

    typedef struct {
        bit          fv;
        logic [31:0] pc;
        bit          sif, sid;
        logic [4:0]  inv;
        logic [4:0]  drd;
        bit          dld;
        bit          e_id_inv;
        logic [31:0] e_id_pc;
        bit          e_ex_inv;
        logic [31:0] e_ex_pc;
        bit          e_wb_inv;
        logic [31:0] e_wb_pc;
        bit          e_ld_ex;
    } vec_t;

    vec_t tbl[9];

    initial begin
        // Straight-line fill from reset, then a one-cycle load-use stall on PC 0x10.
        tbl[0] = '{1, 32'h00, 0, 0, 5'b00000, 0, 0,  1, 32'h00, 1, 32'h00, 1, 32'h00, 0};
        tbl[1] = '{1, 32'h00, 0, 0, 5'b00000, 0, 0,  0, 32'h00, 1, 32'h00, 1, 32'h00, 0};
        tbl[2] = '{1, 32'h04, 0, 0, 5'b00000, 0, 0,  0, 32'h04, 0, 32'h00, 1, 32'h00, 0};
        tbl[3] = '{1, 32'h08, 0, 0, 5'b00000, 0, 0,  0, 32'h08, 0, 32'h04, 1, 32'h00, 0};
        tbl[4] = '{1, 32'h0C, 0, 0, 5'b00000, 0, 0,  0, 32'h0C, 0, 32'h08, 0, 32'h00, 0};
        tbl[5] = '{1, 32'h10, 0, 0, 5'b00000, 0, 0,  0, 32'h10, 0, 32'h0C, 0, 32'h04, 0};
        tbl[6] = '{1, 32'h14, 1, 1, 5'b00100, 5, 1,  0, 32'h10, 1, 32'h0C, 0, 32'h08, 0};
        tbl[7] = '{1, 32'h14, 0, 0, 5'b00000, 5, 1,  0, 32'h14, 0, 32'h10, 0, 32'h0C, 1};
        tbl[8] = '{1, 32'h18, 0, 0, 5'b00000, 0, 0,  0, 32'h18, 0, 32'h14, 1, 32'h0C, 0};

        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1;
        tick();
        chk("reset_ID_invalid", ID_invalid, 1);
        chk("reset_WB_invalid", WB_invalid, 1);
        chk("reset_instret", instret, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].fv, tbl[i].pc, tbl[i].sif, tbl[i].sid, tbl[i].inv, tbl[i].drd, tbl[i].dld);
            tick();
            chk($sformatf("vec%0d_ID_invalid", i), ID_invalid, tbl[i].e_id_inv);
            chk($sformatf("vec%0d_ID_PC", i), ID_PC, tbl[i].e_id_pc);
            chk($sformatf("vec%0d_EX_invalid", i), EX_invalid, tbl[i].e_ex_inv);
            chk($sformatf("vec%0d_EX_PC", i), EX_PC, tbl[i].e_ex_pc);
            chk($sformatf("vec%0d_WB_invalid", i), WB_invalid, tbl[i].e_wb_inv);
            chk($sformatf("vec%0d_WB_PC", i), WB_PC, tbl[i].e_wb_pc);
            chk($sformatf("vec%0d_is_load_EX", i), is_load_EX, tbl[i].e_ld_ex);
        end
        chk("loaduse_stall_cycles", stall_cycles, 1);

        // Branch flush when EX holds 0x20.
        drive(1, 32'h1C, 0, 0, 0, 0, 0); tick();
        drive(1, 32'h20, 0, 0, 0, 0, 0); tick();
        drive(1, 32'h24, 0, 0, 0, 0, 0); tick();
        chk("flush_pre_EX_PC", EX_PC, 32'h20);
        drive(1, 32'h28, 0, 0, 5'b01111, 0, 0); tick();
        chk("flush_ID_invalid", ID_invalid, 1);
        chk("flush_EX_invalid", EX_invalid, 1);
        chk("flush_MEM_invalid", MEM_invalid, 1);
        chk("flush_WB_invalid", WB_invalid, 0);
        chk("flush_WB_PC", WB_PC, 32'h1C);
        chk("flush_cycles_1", flush_cycles, 1);

        // Simultaneous hold and kill of ID.
        drive(1, 32'h40, 0, 0, 0, 0, 0); tick();
        drive(1, 32'h44, 0, 0, 0, 0, 0); tick();
        chk("pre_kill_ID_PC", ID_PC, 32'h44);
        drive(1, 32'h48, 0, 1, 5'b00010, 0, 0); tick();
        chk("kill_ID_invalid", ID_invalid, 1);
        chk("kill_ID_PC", ID_PC, 32'h44);
        chk("kill_EX_invalid", EX_invalid, 1);

        // Reset mid-stream while stalling and flushing.
        drive(1, 32'h4C, 0, 1, 5'b00010, 0, 0);
        reset = 1;
        tick();
        chk("rst_ID_invalid", ID_invalid, 1);
        chk("rst_EX_invalid", EX_invalid, 1);
        chk("rst_MEM_invalid", MEM_invalid, 1);
        chk("rst_WB_invalid", WB_invalid, 1);
        chk("rst_ID_PC", ID_PC, 0);
        chk("rst_WB_PC", WB_PC, 0);
        chk("rst_instret", instret, 0);
        chk("rst_retire", retire, 0);
        chk("rst_stall_cycles", stall_cycles, 0);

        // Straight-line run for counter saturation: 20 retires in 25 edges.
        for (int k = 0; k < 25; k++) begin
            drive(1, 32'(k * 4), 0, 0, 0, 5'(k), 0);
            tick();
        end
        chk("sat_instret64", instret, 20);
        chk("sat_instret4", s_instret, 4'hF);
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'(100 + k * 4), 0, 0, 0, 0, 0);
            tick();
        end
        chk("sat_instret4_hold", s_instret, 4'hF);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            fetch_valid   = ($urandom_range(0, 9) != 0);
            IF_PC         = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            stop_IF       = ($urandom_range(0, 7) == 0);
            stop_ID       = ($urandom_range(0, 7) == 0);
            for (int b = 0; b < 5; b++) si[b] = ($urandom_range(0, 11) == 0);
            dec_rd        = 5'($urandom_range(0, 31));
            dec_is_load   = $urandom_range(0, 1) != 0;
            dec_is_store  = $urandom_range(0, 1) != 0;
            dec_is_branch = $urandom_range(0, 1) != 0;
            reset         = ($urandom_range(0, 59) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
